avb_master_ctrl: RTL



---
 rtl/avb_master_ctrl_if.sv | 35 +++
 rtl/avb_master_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/avb_master_ctrl_if.sv
// Command/response port and Avalon-MM bus of avb_master_ctrl, bundled as one interface.
// master = controller side, slave = command source / Avalon responder side.
interface avb_master_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_address;
  logic [31:0] cmd_writedata;
  logic [3:0]  cmd_byteenable;
  logic        rsp_valid;
  logic [31:0] rsp_readdata;
  logic        rsp_error;
  logic [31:0] avb_address;
  logic        avb_read;
  logic        avb_write;
  logic [31:0] avb_writedata;
  logic [3:0]  avb_byteenable;
  logic        avb_waitrequest;
  logic [31:0] avb_readdata;
  logic        avb_readdatavalid;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable,
           avb_waitrequest, avb_readdata, avb_readdatavalid,
    output cmd_ready, rsp_valid, rsp_readdata, rsp_error,
           avb_address, avb_read, avb_write, avb_writedata, avb_byteenable
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable,
           avb_waitrequest, avb_readdata, avb_readdatavalid,
    input  cmd_ready, rsp_valid, rsp_readdata, rsp_error,
           avb_address, avb_read, avb_write, avb_writedata, avb_byteenable
  );
endinterface

// File: rtl/avb_master_ctrl.sv
// Avalon-MM initiator: one single-beat read/write per command, one response per command,
// waitrequest/readdatavalid handling with a bounded stall timeout.
module avb_master_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic               clock,
  input  logic               resetn,
  avb_master_ctrl_if.master  bus
);

  typedef enum logic [2:0] {IDLE, WR, RD, RDWAIT, RESP} state_t;

  state_t      r_state;
  logic [15:0] r_tmo;
  logic [31:0] r_avb_address;
  logic [31:0] r_avb_writedata;
  logic [3:0]  r_avb_byteenable;
  logic        r_avb_read;
  logic        r_avb_write;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_readdata;
  logic        r_rsp_error;

  logic w_cmd_ready;
  logic w_tmo_hit;

  assign w_cmd_ready = resetn & (r_state == IDLE);
  assign w_tmo_hit   = (r_tmo == 16'(TIMEOUT_CYCLES - 1));

  assign bus.cmd_ready      = w_cmd_ready;
  assign bus.avb_address    = r_avb_address;
  assign bus.avb_writedata  = r_avb_writedata;
  assign bus.avb_byteenable = r_avb_byteenable;
  assign bus.avb_read       = r_avb_read;
  assign bus.avb_write      = r_avb_write;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_readdata   = r_rsp_readdata;
  assign bus.rsp_error      = r_rsp_error;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state          <= IDLE;
      r_tmo            <= '0;
      r_avb_address    <= '0;
      r_avb_writedata  <= '0;
      r_avb_byteenable <= '0;
      r_avb_read       <= 1'b0;
      r_avb_write      <= 1'b0;
      r_rsp_valid      <= 1'b0;
      r_rsp_readdata   <= '0;
      r_rsp_error      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid && w_cmd_ready) begin
            r_avb_address    <= bus.cmd_address;
            r_avb_writedata  <= bus.cmd_writedata;
            r_avb_byteenable <= bus.cmd_byteenable;
            r_tmo            <= '0;
            if (bus.cmd_write) begin
              r_avb_write <= 1'b1;
              r_state     <= WR;
            end else begin
              r_avb_read <= 1'b1;
              r_state    <= RD;
            end
          end
        end
        WR, RD: begin
          // Acceptance is checked before the timeout so a coincident accept wins.
          if (!bus.avb_waitrequest) begin
            r_avb_write <= 1'b0;
            r_avb_read  <= 1'b0;
            r_tmo       <= '0;
            if (r_state == WR) begin
              r_rsp_valid    <= 1'b1;
              r_rsp_error    <= 1'b0;
              r_rsp_readdata <= '0;
              r_state        <= RESP;
            end else begin
              r_state <= RDWAIT;
            end
          end else if (w_tmo_hit) begin
            r_avb_write    <= 1'b0;
            r_avb_read     <= 1'b0;
            r_rsp_valid    <= 1'b1;
            r_rsp_error    <= 1'b1;
            r_rsp_readdata <= '0;
            r_state        <= RESP;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        RDWAIT: begin
          if (bus.avb_readdatavalid) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_error    <= 1'b0;
            r_rsp_readdata <= bus.avb_readdata;
            r_state        <= RESP;
          end else if (w_tmo_hit) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_error    <= 1'b1;
            r_rsp_readdata <= '0;
            r_state        <= RESP;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
